// File: rtl/vga_scan_gen.sv
// Raster scan generator: walks a parameterised VGA frame, presents pixel addresses to the
// tracker, and registers RGB, sync and data-enable from the tracker's 'on' response.
module vga_scan_gen #(
    parameter int          PIX_DIV  = 4,
    parameter int          H_ACTIVE = 480,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 48,
    parameter int          H_BP     = 56,
    parameter int          V_ACTIVE = 270,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 22,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        on,
    output logic [13:0] hcnt,
    output logic [23:0] vcnt,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] DIV_LATCH = DW'(1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
    localparam logic [13:0]   H_LAST    = 14'(H_TOTAL - 1);
    localparam logic [13:0]   V_LAST    = 14'(V_TOTAL - 1);
    localparam logic [13:0]   H_ACT     = 14'(H_ACTIVE);
    localparam logic [13:0]   V_ACT     = 14'(V_ACTIVE);
    localparam logic [13:0]   HS_BEG    = 14'(H_ACTIVE + H_FP);
    localparam logic [13:0]   HS_END    = 14'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [13:0]   VS_BEG    = 14'(V_ACTIVE + V_FP);
    localparam logic [13:0]   VS_END    = 14'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [23:0]   ACC_STEP  = 24'(H_ACTIVE);

    logic [DW-1:0] div_cnt_r;
    logic [13:0]   h_pos_r;
    logic [13:0]   v_line_r;
    logic [23:0]   acc_r;
    logic [13:0]   h_nxt_s;
    logic [13:0]   v_nxt_s;
    logic [23:0]   acc_nxt_s;
    logic          tick_s;
    logic          wrap_frame_s;
    logic          act_nxt_s;
    logic          act_cur_s;
    logic [11:0]   pix_s;

    function automatic logic in_active(input logic [13:0] h, input logic [13:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    function automatic logic sync_level(input logic [13:0] pos, input logic [13:0] beg,
                                        input logic [13:0] fin, input logic pol);
        return ((pos >= beg) && (pos < fin)) ? pol : ~pol;
    endfunction

    // Next raster position, line accumulator and pixel colour.
    always_comb begin
        tick_s       = (div_cnt_r == DIV_LAST);
        wrap_frame_s = 1'b0;
        h_nxt_s      = h_pos_r;
        v_nxt_s      = v_line_r;
        acc_nxt_s    = acc_r;
        if (!tick_s) begin
            h_nxt_s = h_pos_r;
        end else if (h_pos_r != H_LAST) begin
            h_nxt_s = h_pos_r + 14'd1;
        end else if (v_line_r != V_LAST) begin
            h_nxt_s = 14'd0;
            v_nxt_s = v_line_r + 14'd1;
            // Accumulate the linear line offset instead of multiplying.
            if ((v_line_r + 14'd1) < V_ACT) begin
                acc_nxt_s = acc_r + ACC_STEP;
            end else begin
                acc_nxt_s = acc_r;
            end
        end else begin
            h_nxt_s      = 14'd0;
            v_nxt_s      = 14'd0;
            acc_nxt_s    = 24'd0;
            wrap_frame_s = 1'b1;
        end
        act_nxt_s = in_active(h_nxt_s, v_nxt_s);
        act_cur_s = in_active(h_pos_r, v_line_r);
        if (!act_cur_s) begin
            pix_s = 12'h000;
        end else if (on) begin
            pix_s = FG_COLOR;
        end else begin
            pix_s = BG_COLOR;
        end
    end

    // Pixel divider, raster counters and tracker address outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            div_cnt_r   <= DIV_ZERO;
            h_pos_r     <= 14'd0;
            v_line_r    <= 14'd0;
            acc_r       <= 24'd0;
            hcnt        <= 14'd0;
            vcnt        <= 24'd0;
            frame_start <= 1'b0;
        end else begin
            div_cnt_r   <= tick_s ? DIV_ZERO : (div_cnt_r + DIV_ONE);
            h_pos_r     <= h_nxt_s;
            v_line_r    <= v_nxt_s;
            acc_r       <= acc_nxt_s;
            frame_start <= wrap_frame_s;
            // Blanking addresses are forced to 0 so the tracker never indexes out of range.
            if (tick_s) begin
                hcnt <= act_nxt_s ? h_nxt_s : 14'd0;
                vcnt <= act_nxt_s ? acc_nxt_s : 24'd0;
            end else begin
                hcnt <= hcnt;
                vcnt <= vcnt;
            end
        end
    end

    // Output latch one CLK after the tracker response has settled.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            de     <= 1'b0;
            VGA_R  <= 4'h0;
            VGA_G  <= 4'h0;
            VGA_B  <= 4'h0;
            VGA_HS <= ~HS_POL;
            VGA_VS <= ~VS_POL;
        end else if (div_cnt_r == DIV_LATCH) begin
            de     <= act_cur_s;
            VGA_R  <= pix_s[11:8];
            VGA_G  <= pix_s[7:4];
            VGA_B  <= pix_s[3:0];
            VGA_HS <= sync_level(h_pos_r, HS_BEG, HS_END, HS_POL);
            VGA_VS <= sync_level(v_line_r, VS_BEG, VS_END, VS_POL);
        end else begin
            de     <= de;
            VGA_R  <= VGA_R;
            VGA_G  <= VGA_G;
            VGA_B  <= VGA_B;
            VGA_HS <= VGA_HS;
            VGA_VS <= VGA_VS;
        end
    end

endmodule
